v_lsu: RTL and testbench

- Load/store initiator for the CPU memory stage.
- Takes the decoded op, the ALU result and the address from execute, and drives a req/ack data-memory bus to a variable-latency memory responder.
- Stalls the pipeline while a bus transaction is outstanding.
- Returns the write-back value: ALU result, address, load data or 0.

---
 rtl/v_lsu.sv | 148 ++++++++++++++
 tb/tb_v_lsu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_lsu.sv
// v_lsu: load/store initiator for the CPU memory stage.
// Drives a registered req/ack bus to a variable-latency responder, stalls the
// pipeline while a transaction is outstanding and returns the write-back value.
module v_lsu #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [5:0]        op,
  input  logic [31:0]       alu_i,
  input  logic [31:0]       addr_i,
  output logic              stall_o,
  output logic [31:0]       write_o,
  output logic              wb_valid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              err_o
);

  localparam logic [5:0] OP_LW = 6'b010001;
  localparam logic [5:0] OP_SW = 6'b010000;
  localparam int         CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_result;
  logic                r_memReq;
  logic                r_memWe;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [31:0]         r_memWdata;
  logic                r_err;
  logic                w_isMem;
  logic                w_isStore;
  logic                w_cntMax;
  logic [31:0]         w_pass;

  assign w_isStore = (op == OP_SW);
  assign w_isMem   = (op == OP_LW) || w_isStore;
  assign w_cntMax  = (r_cnt == CNT_MAX);

  assign mem_req_o   = r_memReq;
  assign mem_we_o    = r_memWe;
  assign mem_addr_o  = r_memAddr;
  assign mem_wdata_o = r_memWdata;
  assign err_o       = r_err;

  // Select the pass-through write-back value for non-memory ops
  always_comb begin
    w_pass = 32'd0;
    case (op[5:4])
      2'b00:   w_pass = alu_i;
      2'b10:   w_pass = addr_i;
      default: w_pass = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and pipeline-facing outputs; everything is quiet while in reset
  always_comb begin
    w_next     = r_state;
    stall_o    = 1'b0;
    wb_valid_o = 1'b0;
    write_o    = 32'd0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          write_o = w_pass;
          if (valid_i && w_isMem) begin
            stall_o = 1'b1;
            w_next  = S_WAIT;
          end else begin
            wb_valid_o = valid_i;
          end
        end
        S_WAIT: begin
          stall_o = 1'b1;
          if (mem_ack_i || w_cntMax) w_next = S_DONE;
        end
        S_DONE: begin
          wb_valid_o = 1'b1;
          write_o    = r_result;
          w_next     = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Bus registers, timeout counter, result capture and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= 32'd0;
      r_cnt      <= '0;
      r_result   <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i && w_isMem) begin
            r_memReq   <= 1'b1;
            r_memWe    <= w_isStore;
            r_memAddr  <= addr_i[ADDR_W-1:0];
            r_memWdata <= w_isStore ? alu_i : 32'd0;
            r_cnt      <= '0;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            r_result <= r_memWe ? 32'd0 : mem_rdata_i;
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
          end else if (w_cntMax) begin
            r_err    <= 1'b1;
            r_result <= 32'd0;
            r_memReq <= 1'b0;
            r_memWe  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_v_lsu.sv
// tb_v_lsu: scoreboard bench for v_lsu with a behavioural memory responder
// and a word-level reference model of the load/store/pass-through rules.
module tb_v_lsu;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;
  localparam logic [5:0] OP_LW = 6'b010001;
  localparam logic [5:0] OP_SW = 6'b010000;

  logic              clock = 1'b0;
  logic              reset;
  logic              valid_i;
  logic [5:0]        op;
  logic [31:0]       alu_i;
  logic [31:0]       addr_i;
  logic              stall_o;
  logic [31:0]       write_o;
  logic              wb_valid_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i = 32'd0;
  logic              err_o;
  logic              respAck = 1'b0;
  logic              spurAck = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expQ[$];
  logic [31:0] expVal;
  logic [31:0] respMem[256];
  logic [31:0] modelMem[256];
  int          respLatency = 1;
  int          respCnt = 0;
  logic        errExp = 1'b0;

  assign mem_ack_i = respAck | spurAck;

  v_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clock),
    .rst         (reset),
    .valid_i     (valid_i),
    .op          (op),
    .alu_i       (alu_i),
    .addr_i      (addr_i),
    .stall_o     (stall_o),
    .write_o     (write_o),
    .wb_valid_o  (wb_valid_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .err_o       (err_o)
  );

  // Free-running clock
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory responder: acks on the respLatency-th cycle that req is seen high
  // (0 means never); stores write its own array, loads read from it
  always @(posedge clock) begin
    #1;
    if (mem_req_o === 1'b1) begin
      respCnt = respCnt + 1;
      if (respLatency != 0 && respCnt == respLatency) begin
        respAck = 1'b1;
        if (mem_we_o === 1'b1) begin
          respMem[mem_addr_o] = mem_wdata_o;
          mem_rdata_i = $urandom;
        end else begin
          mem_rdata_i = respMem[mem_addr_o];
        end
      end else begin
        respAck = 1'b0;
        mem_rdata_i = $urandom;
      end
    end else begin
      respCnt = 0;
      respAck = 1'b0;
      mem_rdata_i = $urandom;
    end
  end

  // Scoreboard monitor: every write-back must match the oldest expected value
  always @(negedge clock) begin
    if (wb_valid_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedWb: actual wb_valid_o=1 write_o=%h required no write-back", write_o);
      end else begin
        expVal = expQ.pop_front();
        checkOutput("writeBack", write_o, expVal);
      end
    end
  end

  // Issue one instruction, push its expected write-back, follow it to completion
  task automatic applyStimulus(input logic [5:0] o, input logic [31:0] a,
                               input logic [31:0] ad, input int lat);
    bit          isMem;
    bit          isStore;
    bit          timedOut;
    bit          busOk;
    int          expStall;
    int          stallCnt;
    logic [31:0] expWr;
    logic [7:0]  wAddr;
    isMem    = (o == OP_LW) || (o == OP_SW);
    isStore  = (o == OP_SW);
    wAddr    = ad[7:0];
    timedOut = isMem && (lat < 1 || lat > TIMEOUT);
    respLatency = lat;
    if (!isMem) begin
      expStall = 0;
      case (o[5:4])
        2'b00:   expWr = a;
        2'b10:   expWr = ad;
        default: expWr = 32'd0;
      endcase
    end else if (timedOut) begin
      expStall = 1 + TIMEOUT;
      expWr    = 32'd0;
      errExp   = 1'b1;
    end else begin
      expStall = 1 + lat;
      if (isStore) begin
        modelMem[wAddr] = a;
        expWr = 32'd0;
      end else begin
        expWr = modelMem[wAddr];
      end
    end
    expQ.push_back(expWr);
    valid_i = 1'b1;
    op      = o;
    alu_i   = a;
    addr_i  = ad;
    stallCnt = 0;
    busOk    = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (c == 0) checkOutput("reqLowAtIssue", 32'(mem_req_o), 32'd0);
      if (stall_o !== 1'b1) break;
      stallCnt++;
      if (c > 0) begin
        if (mem_req_o !== 1'b1 || mem_addr_o !== wAddr || mem_we_o !== isStore ||
            mem_wdata_o !== (isStore ? a : 32'd0))
          busOk = 1'b0;
      end
      @(posedge clock);
      #2;
    end
    checkOutput("stallCycles", 32'(stallCnt), 32'(expStall));
    if (isMem) begin
      checkOutput("busHeld", 32'(busOk), 32'd1);
      checkOutput("reqLowInDone", 32'(mem_req_o), 32'd0);
    end
    checkOutput("errFlag", 32'(err_o), 32'(errExp));
    @(posedge clock);
    #2;
    valid_i = 1'b0;
  endtask

  // Global watchdog so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    logic [31:0] v;
    int          kind;
    logic [5:0]  ro;
    logic [31:0] ra;
    reset   = 1'b1;
    valid_i = 1'b1;
    op      = 6'b000000;
    alu_i   = 32'h55;
    addr_i  = 32'd0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      respMem[i]  = v;
      modelMem[i] = v;
    end
    @(negedge clock);
    checkOutput("rstStall", 32'(stall_o), 32'd0);
    checkOutput("rstWbValid", 32'(wb_valid_o), 32'd0);
    checkOutput("rstWrite", write_o, 32'd0);
    repeat (2) @(posedge clock);
    #2;
    reset   = 1'b0;
    valid_i = 1'b0;
    @(negedge clock);
    checkOutput("rstReq", 32'(mem_req_o), 32'd0);
    checkOutput("rstWe", 32'(mem_we_o), 32'd0);
    checkOutput("rstAddr", 32'(mem_addr_o), 32'd0);
    checkOutput("rstWdata", mem_wdata_o, 32'd0);
    checkOutput("rstErr", 32'(err_o), 32'd0);
    @(posedge clock);
    #2;

    applyStimulus(6'b000011, 32'h1234, 32'h0, 1);
    applyStimulus(6'b100000, 32'h0, 32'h40, 1);
    applyStimulus(OP_SW, 32'hDEADBEEF, 32'h05, 1);
    applyStimulus(OP_LW, 32'h0, 32'h105, 1);
    applyStimulus(OP_LW, 32'h0, 32'h0000_0A05, 5);
    applyStimulus(OP_SW, 32'hCAFE0001, 32'h22, 5);
    applyStimulus(OP_LW, 32'h0, 32'h22, 1);
    applyStimulus(OP_LW, 32'h0, 32'h05, 1);

    valid_i = 1'b0;
    spurAck = 1'b1;
    @(negedge clock);
    checkOutput("spurStall", 32'(stall_o), 32'd0);
    checkOutput("spurReq", 32'(mem_req_o), 32'd0);
    @(posedge clock);
    #2;
    spurAck = 1'b0;
    @(negedge clock);
    checkOutput("spurIdleStall", 32'(stall_o), 32'd0);
    @(posedge clock);
    #2;
    applyStimulus(6'b001111, 32'h0BADF00D, 32'h0, 1);

    applyStimulus(OP_SW, 32'h12345678, 32'h77, 16);
    applyStimulus(OP_LW, 32'h0, 32'h177, 16);
    applyStimulus(OP_LW, 32'h0, 32'h77, 0);
    applyStimulus(6'b000001, 32'hA5A5A5A5, 32'h0, 1);
    applyStimulus(OP_SW, 32'h11111111, 32'h30, 0);
    applyStimulus(OP_LW, 32'h0, 32'h30, 2);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0:       ro = {2'b00, 4'($urandom)};
        1:       ro = {2'b10, 4'($urandom)};
        2:       ro = {2'b11, 4'($urandom)};
        3:       ro = OP_LW;
        4:       ro = OP_SW;
        default: ro = {2'b01, 4'($urandom_range(2, 15))};
      endcase
      ra = {24'($urandom), 4'd0, 4'($urandom)};
      applyStimulus(ro, $urandom, ra, $urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) begin
        op    = 6'($urandom);
        alu_i = $urandom;
        @(negedge clock);
        checkOutput("idleNoStall", 32'(stall_o), 32'd0);
        @(posedge clock);
        #2;
      end
    end

    respLatency = 0;
    valid_i = 1'b1;
    op      = OP_LW;
    addr_i  = 32'h3;
    alu_i   = 32'h0;
    @(posedge clock);
    #2;
    @(posedge clock);
    #2;
    reset   = 1'b1;
    valid_i = 1'b0;
    @(negedge clock);
    checkOutput("midRstStall", 32'(stall_o), 32'd0);
    checkOutput("midRstWbValid", 32'(wb_valid_o), 32'd0);
    @(posedge clock);
    #2;
    @(negedge clock);
    checkOutput("midRstReqDrop", 32'(mem_req_o), 32'd0);
    @(posedge clock);
    #2;
    reset  = 1'b0;
    errExp = 1'b0;
    @(negedge clock);
    checkOutput("postRstReq", 32'(mem_req_o), 32'd0);
    checkOutput("postRstErr", 32'(err_o), 32'd0);
    checkOutput("postRstStall", 32'(stall_o), 32'd0);
    @(posedge clock);
    #2;
    spurAck = 1'b1;
    @(posedge clock);
    #2;
    spurAck = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    applyStimulus(OP_LW, 32'h0, 32'h22, 2);

    repeat (2) @(posedge clock);
    #2;
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
